// File: rtl/axi_wr_master.sv
// Burst write-data master: a key pulse emits data_len beats of DATA_INIT + k*DATA_STEP over VALID/READY/LAST.
// Optional stall timeout is compiled in with `define AXI_WR_MASTER_TIMEOUT_EN.
module axi_wr_master #(
    parameter int unsigned data_len    = 256,
    parameter logic [31:0] DATA_INIT   = 32'd1,
    parameter logic [31:0] DATA_STEP   = 32'd1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        key,
    input  logic        M_WREADY,
    output logic [31:0] M_WDATA,
    output logic        M_WVALID,
    output logic        M_WLAST,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(data_len - 1);

    if (data_len < 1 || data_len > 65535 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("axi_wr_master: illegal data_len or TIMEOUT_CYC");
    end

    // Payload arithmetic wraps modulo 2^32 by construction.
    function automatic logic [31:0] next_beat(input logic [31:0] cur);
        return cur + DATA_STEP;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        vld_q, vld_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

`ifdef AXI_WR_MASTER_TIMEOUT_EN
    localparam logic [31:0] STALL_LIM = 32'(TIMEOUT_CYC - 1);
    logic [31:0] stall_q, stall_d;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        vld_d   = vld_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
`ifdef AXI_WR_MASTER_TIMEOUT_EN
        stall_d = stall_q;
`endif
        case (state_q)
            IDLE: begin
                if (key) begin
                    state_d = SEND;
                    data_d  = DATA_INIT;
                    vld_d   = 1'b1;
                    last_d  = (LAST_IDX == 16'd0);
                    busy_d  = 1'b1;
                    cnt_d   = 16'd0;
`ifdef AXI_WR_MASTER_TIMEOUT_EN
                    stall_d = 32'd0;
`endif
                end
            end
            SEND: begin
                if (vld_q && M_WREADY) begin
`ifdef AXI_WR_MASTER_TIMEOUT_EN
                    stall_d = 32'd0;
`endif
                    if (last_q) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = 16'd0;
                    end else begin
                        data_d = next_beat(data_q);
                        cnt_d  = cnt_q + 16'd1;
                        last_d = ((cnt_q + 16'd1) == LAST_IDX);
                    end
                end
`ifdef AXI_WR_MASTER_TIMEOUT_EN
                // A transfer takes the branch above, so it always wins over the abort.
                else if (vld_q) begin
                    if (stall_q == STALL_LIM) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        cnt_d   = 16'd0;
                        stall_d = 32'd0;
                    end else begin
                        stall_d = stall_q + 32'd1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            data_q  <= 32'd0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef AXI_WR_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    assign M_WDATA  = data_q;
    assign M_WVALID = vld_q;
    assign M_WLAST  = last_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: doc/axi_wr_master.md
# axi_wr_master

Write-data master that generates a fixed-length burst of 32-bit words and drives them into the write slave over a VALID/READY/LAST channel. It sits directly upstream of the write slave, which asserts READY when its own `key` fires and deasserts READY after it sees LAST. A `key` pulse starts one burst. Payload is a deterministic arithmetic sequence, so the slave's captured data can be checked beat by beat.

## Interface
- `data_len`, 256: beats per burst; legal range 1..65535.
- `DATA_INIT`, 32'd1: payload of beat 0.
- `DATA_STEP`, 32'd1: increment between consecutive beats.
- `TIMEOUT_CYC`, 1024: stall limit in cycles. Only used when the timeout feature is compiled in.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `key`, input, 1: burst start request, sampled on `clk`.
- `M_WREADY`, input, 1: slave ready.
- `M_WDATA`, output, 32: write data.
- `M_WVALID`, output, 1: data valid.
- `M_WLAST`, output, 1: final beat of the burst.
- `busy`, output, 1: burst in progress.
- `done`, output, 1: one-cycle pulse when a burst completes.
- `err`, output, 1: one-cycle pulse on timeout abort.

## Operation
- Reset values, all registered: `M_WDATA`=0, `M_WVALID`=0, `M_WLAST`=0, `busy`=0, `done`=0, `err`=0. State is IDLE and the beat counter is 0.
- States are IDLE and SEND.
- **IDLE**
  - `key`=1 at an edge moves to SEND.
  - On that edge: `M_WVALID`=1, `M_WDATA`=`DATA_INIT`, `busy`=1.
  - `M_WLAST`=1 immediately if `data_len`==1.
  - VALID never waits for READY.
- **SEND**
  - A beat transfers at any edge where `M_WVALID` and `M_WREADY` are both 1.
  - Beat k carries `DATA_INIT + k*DATA_STEP`, computed modulo 2^32, wrapping silently.
  - The beat counter is 16 bits, counts transfers, and never exceeds `data_len-1`.
- **Non-final beat transfer:** at the same edge, `M_WDATA` advances by `DATA_STEP` and the counter increments. `M_WLAST` becomes 1 when the new counter equals `data_len-1`.
- **Final beat transfer** (`M_WLAST`=1):
  - `M_WVALID`, `M_WLAST` and `busy` clear to 0.
  - `done`=1 for exactly the next cycle.
  - State returns to IDLE.
  - `M_WDATA` holds its last value.
- **Backpressure:** while `M_WVALID`=1 and `M_WREADY`=0, `M_WDATA` and `M_WLAST` hold stable. VALID is never withdrawn except by reset or timeout.
- `key` is ignored while `busy`=1, and is also ignored in the `done` cycle's preceding edge; no queueing.
- `M_WREADY` is ignored in IDLE.
- Reset mid-burst forces every output to its reset value immediately, since reset is asynchronous. No partial-burst state survives.

## Timing
- Start latency: `key` high at edge n means the first beat is valid in the cycle after edge n.
- With READY constantly high, beat k is presented in cycle n+1+k and the burst occupies `data_len` cycles.
- `done` is high in cycle n+1+`data_len`.
- Minimum `key`-to-`key` period for back-to-back bursts is `data_len`+1 cycles: a new `key` is accepted at the edge that ends the `done` cycle.
- No combinational path from any input to any output.

## Configuration
- Macro `AXI_WR_MASTER_TIMEOUT_EN`.
- **Defined:**
  - A stall counter counts consecutive SEND cycles with `M_WVALID`=1 and `M_WREADY`=0. It clears on any transfer.
  - When the count reaches `TIMEOUT_CYC`, the block aborts at the next edge: `M_WVALID`, `M_WLAST` and `busy` clear to 0, `err`=1 for one cycle, `done` stays 0, and state returns to IDLE.
  - A transfer at the same edge as the limit wins over the abort.
- **Undefined:** no stall counter; `err` is tied to 0; the block waits for READY indefinitely.

## Test plan
- **Normal burst:** `data_len`=4, init 1, step 1, READY held high, `key` pulse. Expect data 1, 2, 3, 4 on consecutive cycles, LAST only with 4, then `done` for one cycle and `busy` low.
- **Backpressure:** `data_len`=4, READY pattern 1,0,0,1,0,1,1. Expect each beat held stable while READY=0. The slave captures exactly 1, 2, 3, 4 and LAST holds with beat 4 until it transfers.
- **Single beat:** `data_len`=1, init 32'hFFFFFFFF, step 2. Expect VALID and LAST together on the first cycle, data FFFFFFFF, `done` next cycle. Repeat with `data_len`=3 to check wrap: FFFFFFFF, 1, 3.
- **Ignored key:** `key` pulsed during beat 2 of a 4-beat burst. Expect no effect on the count or data, and no second burst.
- **Reset mid-burst:** assert `rstn`=0 during beat 2. Expect all outputs 0 asynchronously. After release, a new `key` restarts from `DATA_INIT`.
- **Timeout (macro defined):** `TIMEOUT_CYC`=8, READY held low. Expect VALID high for 8 cycles, then `err` for one cycle, VALID/`busy` low, and `done` never asserted.
